// File: rtl/icb_fb_slave_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icb_fb_slave_pkg : shared widths, window bases and register offsets
// Revision: 1.0
// ---------------------------------------------------------------------------
package icb_fb_slave_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam int PIX_W  = 24;

  localparam logic [ADDR_W-1:0] FB_BASE_DEF   = 64'h00000000a1000000;
  localparam logic [ADDR_W-1:0] CTRL_BASE_DEF = 64'h00000000a0000000;
  localparam logic [ADDR_W-1:0] STATUS_OFF    = 64'h100;
  localparam logic [ADDR_W-1:0] SYNC_OFF      = 64'h104;

  typedef enum logic [1:0] {
    REGION_NONE   = 2'd0,
    REGION_FB     = 2'd1,
    REGION_STATUS = 2'd2,
    REGION_SYNC   = 2'd3
  } region_e;

endpackage
`default_nettype wire

// File: rtl/fb_dpram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_dpram : 2**AW x 24 pixel RAM, port A byte-write + registered read,
//            port B registered read (read-before-write on collisions)
// Revision: 1.0
// ---------------------------------------------------------------------------
module fb_dpram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en_a,
  input  logic          re_a,
  input  logic [2:0]    we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [23:0]   wdata_a,
  output logic [23:0]   rdata_a,
  input  logic [AW-1:0] addr_b,
  output logic [23:0]   rdata_b
);

  logic [23:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (en_a) begin
      if (we_a[0]) mem[addr_a][7:0]   <= wdata_a[7:0];
      if (we_a[1]) mem[addr_a][15:8]  <= wdata_a[15:8];
      if (we_a[2]) mem[addr_a][23:16] <= wdata_a[23:16];
      // Output only moves on reads so a held response keeps its data
      if (re_a) rdata_a <= mem[addr_a];
    end
  end

  always_ff @(posedge clk) begin
    rdata_b <= mem[addr_b];
  end

endmodule
`default_nettype wire

// File: rtl/icb_fb_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icb_fb_slave : ICB slave with a pixel framebuffer window and STATUS/SYNC
//                control registers; single-entry response register
// Revision: 1.0
// ---------------------------------------------------------------------------
module icb_fb_slave
  import icb_fb_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE   = FB_BASE_DEF,
  parameter int                FB_AW     = 12,
  parameter logic [ADDR_W-1:0] CTRL_BASE = CTRL_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_vld,
  output logic              icb_cmd_rdy,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [DATA_W-1:0] icb_cmd_wdata,
  input  logic [MASK_W-1:0] icb_cmd_wmask,
  output logic              icb_rsp_vld,
  input  logic              icb_rsp_rdy,
  output logic [DATA_W-1:0] icb_rsp_rdata,
  output logic              icb_rsp_err,
  input  logic [FB_AW-1:0]  pix_raddr,
  output logic [PIX_W-1:0]  pix_rdata,
  output logic              sync_pulse,
  output logic              fb_ready
);

  localparam logic [ADDR_W-1:0] FB_BYTES = ADDR_W'(64'd4 << FB_AW);

  logic [ADDR_W-1:0] fb_off;
  region_e           region;
  logic              accept;
  logic              ram_en;
  logic              ram_re;
  logic [2:0]        ram_we;
  logic              sync_hit;
  logic [31:0]       frame_cnt;
  logic [DATA_W-1:0] status_word;
  logic              rsp_from_ram;
  logic [DATA_W-1:0] rsp_data;
  logic [PIX_W-1:0]  ram_qa;
  logic              unused_bits;

  assign fb_off = icb_cmd_addr - FB_BASE;

  always_comb begin
    region = REGION_NONE;
    if ((icb_cmd_addr >= FB_BASE) && (fb_off < FB_BYTES))
      region = REGION_FB;
    else if (icb_cmd_addr == CTRL_BASE + STATUS_OFF)
      region = REGION_STATUS;
    else if (icb_cmd_addr == CTRL_BASE + SYNC_OFF)
      region = REGION_SYNC;
  end

  // Blocking accepts during reset keeps a mid-reset command from touching RAM
  assign icb_cmd_rdy = !rst && (!icb_rsp_vld || icb_rsp_rdy);
  assign accept      = icb_cmd_vld && icb_cmd_rdy;
  assign ram_en      = accept && (region == REGION_FB);
  assign ram_re      = ram_en && icb_cmd_read;
  assign ram_we      = (ram_en && !icb_cmd_read) ? icb_cmd_wmask[2:0] : 3'b000;
  assign sync_hit    = accept && !icb_cmd_read && (region == REGION_SYNC)
                       && icb_cmd_wmask[0] && icb_cmd_wdata[0];
  assign status_word = {31'd0, fb_ready, frame_cnt};

  fb_dpram #(.AW(FB_AW)) u_ram (
    .clk     (clk),
    .en_a    (ram_en),
    .re_a    (ram_re),
    .we_a    (ram_we),
    .addr_a  (fb_off[FB_AW+1:2]),
    .wdata_a (icb_cmd_wdata[PIX_W-1:0]),
    .rdata_a (ram_qa),
    .addr_b  (pix_raddr),
    .rdata_b (pix_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icb_rsp_vld  <= 1'b0;
      icb_rsp_err  <= 1'b0;
      rsp_from_ram <= 1'b0;
      rsp_data     <= '0;
    end else if (accept) begin
      icb_rsp_vld  <= 1'b1;
      icb_rsp_err  <= (region == REGION_NONE);
      rsp_from_ram <= (region == REGION_FB) && icb_cmd_read;
      rsp_data     <= (icb_cmd_read && (region == REGION_STATUS)) ? status_word : '0;
    end else if (icb_rsp_rdy) begin
      icb_rsp_vld  <= 1'b0;
    end
  end

  assign icb_rsp_rdata = rsp_from_ram ? {{(DATA_W-PIX_W){1'b0}}, ram_qa} : rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pulse <= 1'b0;
      fb_ready   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      sync_pulse <= sync_hit;
      if (sync_hit) begin
        fb_ready  <= 1'b1;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

  assign unused_bits = ^{icb_cmd_wdata[DATA_W-1:PIX_W], icb_cmd_wmask[MASK_W-1:3],
                         fb_off[ADDR_W-1:FB_AW+2], fb_off[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_icb_fb_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_icb_fb_slave : directed stimulus with a response scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_icb_fb_slave;

  localparam logic [63:0] FB   = 64'h00000000a1000000;
  localparam logic [63:0] CTRL = 64'h00000000a0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icb_cmd_vld = 1'b0;
  logic        icb_cmd_rdy;
  logic [63:0] icb_cmd_addr = '0;
  logic        icb_cmd_read = 1'b0;
  logic [63:0] icb_cmd_wdata = '0;
  logic [7:0]  icb_cmd_wmask = '0;
  logic        icb_rsp_vld;
  logic        icb_rsp_rdy = 1'b1;
  logic [63:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic [11:0] pix_raddr = '0;
  logic [23:0] pix_rdata;
  logic        sync_pulse;
  logic        fb_ready;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   sync_cnt = 0;

  icb_fb_slave dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_vld   (icb_cmd_vld),
    .icb_cmd_rdy   (icb_cmd_rdy),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_vld   (icb_rsp_vld),
    .icb_rsp_rdy   (icb_rsp_rdy),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .pix_raddr     (pix_raddr),
    .pix_rdata     (pix_rdata),
    .sync_pulse    (sync_pulse),
    .fb_ready      (fb_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake visible at the negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst && icb_rsp_vld && icb_rsp_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b expected no response", icb_rsp_rdata, icb_rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", {63'd0, icb_rsp_err}, {63'd0, e.err});
        chk("rsp_rdata", icb_rsp_rdata, e.rdata);
      end
    end
    if (sync_pulse) sync_cnt++;
  end

  // Call at posedge+1; returns at posedge+1 after the command is accepted
  task automatic send(input logic [63:0] a, input logic rd, input logic [63:0] wd,
                      input logic [7:0] wm, input logic e, input logic [63:0] rdv);
    int n;
    exp_t x;
    n = 0;
    icb_cmd_vld   = 1'b1;
    icb_cmd_addr  = a;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    @(negedge clk);
    while (!icb_cmd_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!icb_cmd_rdy) begin
      total++;
      bad++;
      $display("FAIL cmd_timeout: got cmd_rdy=0 expected 1 for addr %h", a);
    end else begin
      x.err   = e;
      x.rdata = rdv;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    icb_cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_rsp_vld", {63'd0, icb_rsp_vld}, 64'd0);
    chk("reset_rsp_rdata", icb_rsp_rdata, 64'd0);
    chk("reset_rsp_err", {63'd0, icb_rsp_err}, 64'd0);
    chk("reset_sync_pulse", {63'd0, sync_pulse}, 64'd0);
    chk("reset_fb_ready", {63'd0, fb_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'd0);

    // Fill the framebuffer, then scan it out
    for (int i = 0; i < 2400; i++)
      send(FB + 64'(i * 4), 1'b0, {8'd0, 24'hff00ff, 8'd0, 24'hff00ff}, 8'hff, 1'b0, 64'd0);
    drain();
    for (int i = 0; i < 2400; i++) begin
      pix_raddr = 12'(i);
      @(posedge clk);
      #1;
      chk("pix_scan", {40'd0, pix_rdata}, {40'd0, 24'hff00ff});
    end

    // SYNC write: one pulse, fb_ready, frame count
    sync_cnt = 0;
    send(CTRL + 64'h104, 1'b0, 64'd1, 8'h0f, 1'b0, 64'd0);
    chk("sync_pulse_high", {63'd0, sync_pulse}, 64'd1);
    @(posedge clk);
    #1;
    chk("sync_pulse_low", {63'd0, sync_pulse}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sync_pulse_count", 64'(sync_cnt), 64'd1);
    chk("fb_ready_set", {63'd0, fb_ready}, 64'd1);
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0001_0000_0001);
    send(CTRL + 64'h104, 1'b1, 64'd0, 8'h00, 1'b0, 64'd0);
    send(CTRL + 64'h104, 1'b0, 64'd2, 8'hff, 1'b0, 64'd0);
    send(CTRL + 64'h100, 1'b0, 64'hffff, 8'hff, 1'b0, 64'd0);
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0001_0000_0001);
    drain();
    chk("sync_no_extra_pulse", 64'(sync_cnt), 64'd1);

    // Partial byte mask, then read back through both ports
    send(FB + 64'd20, 1'b0, 64'h123456, 8'hff, 1'b0, 64'd0);
    send(FB + 64'd20, 1'b0, 64'hAB0000, 8'h04, 1'b0, 64'd0);
    send(FB + 64'd20, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0000_00AB_3456);
    send(FB + 64'd22, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0000_00AB_3456);
    pix_raddr = 12'd5;
    @(posedge clk);
    #1;
    chk("pix_partial", {40'd0, pix_rdata}, 64'h00AB_3456);
    drain();

    // Stalled response: ready must drop, then back-to-back ordering
    icb_rsp_rdy = 1'b0;
    send(FB + 64'd28, 1'b0, 64'h111111, 8'hff, 1'b0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cmd_rdy", {63'd0, icb_cmd_rdy}, 64'd0);
      chk("stall_rsp_vld", {63'd0, icb_rsp_vld}, 64'd1);
    end
    @(posedge clk);
    #1;
    icb_rsp_rdy = 1'b1;
    send(FB + 64'd28, 1'b1, 64'd0, 8'h00, 1'b0, 64'h111111);
    send(FB + 64'd32, 1'b0, 64'h222222, 8'h07, 1'b0, 64'd0);
    send(FB + 64'd32, 1'b1, 64'd0, 8'h00, 1'b0, 64'h222222);
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0001_0000_0001);
    drain();

    // Decode errors and window edges
    send(CTRL + 64'h200, 1'b1, 64'd0, 8'h00, 1'b1, 64'd0);
    send(64'h00000000a2000000, 1'b0, 64'h1, 8'hff, 1'b1, 64'd0);
    send(CTRL + 64'h108, 1'b1, 64'd0, 8'h00, 1'b1, 64'd0);
    send(FB + 64'h4000, 1'b0, 64'h333333, 8'hff, 1'b1, 64'd0);
    send(FB + 64'h4000, 1'b1, 64'd0, 8'h00, 1'b1, 64'd0);
    send(FB + 64'h3ffc, 1'b0, 64'h444444, 8'hff, 1'b0, 64'd0);
    send(FB + 64'h3ffc, 1'b1, 64'd0, 8'h00, 1'b0, 64'h444444);
    send(FB, 1'b1, 64'd0, 8'h00, 1'b0, 64'hff00ff);
    send(FB + 64'd20, 1'b1, 64'd0, 8'h00, 1'b0, 64'h00AB_3456);
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0001_0000_0001);
    drain();

    // Async reset with a response pending
    icb_rsp_rdy = 1'b0;
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'h0000_0001_0000_0001);
    @(negedge clk);
    chk("pending_rsp_vld", {63'd0, icb_rsp_vld}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rsp_vld", {63'd0, icb_rsp_vld}, 64'd0);
    chk("async_fb_ready", {63'd0, fb_ready}, 64'd0);
    chk("async_rsp_rdata", icb_rsp_rdata, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    icb_rsp_rdy = 1'b1;
    send(CTRL + 64'h100, 1'b1, 64'd0, 8'h00, 1'b0, 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
